kf8237_dma_device: RTL

//  Peripheral-side endpoint of the KF8237 DREQ/DACK protocol: the device that requests DMA and services
//  the controller's IOR/IOW strobes. Buffers bytes in a FIFO between a local device interface and the

---
 rtl/kf8237_dma_device_if.sv | 23 ++
 rtl/kf8237_dma_device.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/kf8237_dma_device_if.sv
// DREQ/DACK system-bus signals between one KF8237 channel (master) and a
// peripheral DMA endpoint (slave).
interface kf8237_dma_device_if;
  logic       dma_request;
  logic       dma_acknowledge;
  logic       io_read_n_in;
  logic       io_write_n_in;
  logic       end_of_process_in;
  logic       end_of_process_out;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;
  logic       data_bus_out_enable;

  modport master (
    input  dma_request, end_of_process_out, data_bus_out, data_bus_out_enable,
    output dma_acknowledge, io_read_n_in, io_write_n_in, end_of_process_in, data_bus_in
  );

  modport slave (
    output dma_request, end_of_process_out, data_bus_out, data_bus_out_enable,
    input  dma_acknowledge, io_read_n_in, io_write_n_in, end_of_process_in, data_bus_in
  );
endinterface

// File: rtl/kf8237_dma_device.sv
// Peripheral-side KF8237 DMA endpoint: byte FIFO between a local device port
// and the system data bus, DREQ generation, IOR/IOW strobe servicing, EOP.
// Optional feature macro: KF8237_DEVICE_EOP_OUT_EN adds a transfer length
// counter that drives end_of_process_out on the final byte.
module kf8237_dma_device #(
  parameter  int FIFO_DEPTH    = 8,
  parameter  int REQ_THRESHOLD = 4,
  localparam int AW            = $clog2(FIFO_DEPTH),
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          direction,
  input  logic          done_clear,
  input  logic          local_write,
  input  logic [7:0]    local_wdata,
  input  logic          local_read,
  output logic [7:0]    local_rdata,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          transfer_done,
  output logic          underrun,
  output logic          overrun,
`ifdef KF8237_DEVICE_EOP_OUT_EN
  input  logic          length_load,
  input  logic [15:0]   length_value,
`endif
  kf8237_dma_device_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_ACTIVE, S_RELEASE} state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic          ior_n_q, iow_n_q;
  logic [7:0]    bus_q, bus_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, free_cnt;
  logic          done_q, done_d, under_q, under_d, over_q, over_d;

  logic dir_eff, ior_end, iow_end;
  logic dma_pop_req, dma_push_req, dma_pop, dma_push, loc_push, loc_pop;
  logic push, pop, xfer, last_byte, thresh_ok, len_ok, eop_out, eop_any, set_done;
  logic [7:0] push_data;

  // Direction follows the pin while idle and is frozen for the whole burst.
  assign dir_eff  = (state_q == S_IDLE) ? direction : dir_q;
  // A strobe ends on its rising edge, and only counts while acknowledged.
  assign ior_end  = bus.dma_acknowledge & ~ior_n_q & bus.io_read_n_in;
  assign iow_end  = bus.dma_acknowledge & ~iow_n_q & bus.io_write_n_in;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign free_cnt   = CW'(FIFO_DEPTH) - count_q;
  assign fifo_count = count_q;
  assign local_rdata = mem_q[rd_ptr_q];

  // DMA side owns the single write/read port when it moves a byte; the local
  // side of the same kind is dropped in that (controller-timed) cycle.
  assign dma_pop_req  = ior_end & ~dir_eff;
  assign dma_push_req = iow_end &  dir_eff;
  assign dma_pop      = dma_pop_req  & ~fifo_empty;
  assign dma_push     = dma_push_req & ~fifo_full;
  assign loc_push     = local_write & ~fifo_full  & ~dma_push;
  assign loc_pop      = local_read  & ~fifo_empty & ~dma_pop;
  assign push         = dma_push | loc_push;
  assign pop          = dma_pop  | loc_pop;
  assign push_data    = dma_push ? bus_q : local_wdata;
  assign xfer         = dma_pop | dma_push;

  // Final byte of a burst: FIFO drained (D2M) or filled (M2D) by this strobe.
  assign last_byte = dir_q ? (dma_push && count_q == CW'(FIFO_DEPTH - 1))
                           : (dma_pop && count_q == CW'(1) && !loc_push);
  assign thresh_ok = direction ? (free_cnt >= CW'(REQ_THRESHOLD))
                               : (count_q  >= CW'(REQ_THRESHOLD));

`ifdef KF8237_DEVICE_EOP_OUT_EN
  logic [15:0] len_q, len_d;
  logic        strobe_low;
  assign strobe_low = bus.dma_acknowledge & (dir_eff ? ~bus.io_write_n_in : ~bus.io_read_n_in);
  assign eop_out    = strobe_low & (len_q == 16'd1);
  assign len_ok     = (len_q != 16'd0);

  // Length counter: loaded only while idle, counts actually moved bytes.
  always_comb begin
    len_d = len_q;
    if (state_q == S_IDLE && length_load) len_d = length_value;
    else if (xfer && len_q != 16'd0)      len_d = len_q - 16'd1;
  end

  // Length counter register.
  always_ff @(posedge clock) begin
    if (reset) len_q <= '0;
    else       len_q <= len_d;
  end
`else
  assign eop_out = 1'b0;
  assign len_ok  = 1'b1;
`endif

  // Self-generated EOP ends the burst exactly like one from the controller.
  assign eop_any = bus.dma_acknowledge & (bus.end_of_process_in | eop_out);

  assign bus.end_of_process_out  = eop_out;
  assign bus.dma_request         = (state_q == S_REQUEST) || (state_q == S_ACTIVE);
  assign bus.data_bus_out_enable = bus.dma_acknowledge & ~bus.io_read_n_in & ~dir_eff;
  assign bus.data_bus_out        = (bus.data_bus_out_enable && !fifo_empty) ? mem_q[rd_ptr_q] : 8'hFF;
  assign transfer_done = done_q;
  assign underrun      = under_q;
  assign overrun       = over_q;

  // Request FSM next state; losing DACK mid-burst (preemption) keeps requesting.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    set_done = 1'b0;
    case (state_q)
      S_IDLE: if (enable && thresh_ok && len_ok) begin
        state_d = S_REQUEST;
        dir_d   = direction;
      end
      S_REQUEST: begin
        if (eop_any) begin
          state_d  = S_RELEASE;
          set_done = 1'b1;
        end else if (bus.dma_acknowledge) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (eop_any) begin
          state_d  = S_RELEASE;
          set_done = 1'b1;
        end else if (last_byte) state_d = S_RELEASE;
      end
      S_RELEASE: if (!bus.dma_acknowledge) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy, bus capture and sticky flags (set beats clear).
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    bus_d    = (!bus.io_read_n_in || !bus.io_write_n_in) ? bus.data_bus_in : bus_q;
    done_d   = set_done | (done_q & ~done_clear);
    under_d  = (dma_pop_req  & fifo_empty) | (under_q & ~done_clear);
    over_d   = (dma_push_req & fifo_full)  | (over_q  & ~done_clear);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      bus_q    <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      ior_n_q  <= bus.io_read_n_in;
      iow_n_q  <= bus.io_write_n_in;
      bus_q    <= bus_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule
